// File: rtl/timer_pkg.sv
// timer_pkg: shared state codes, default timing constants and BCD limit for the countdown timer control
package timer_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4,
    FAULT = 3'd5
  } state_t;
  localparam logic [15:0] DB_CYCLES_DEF  = 16'd50000;
  localparam logic [7:0]  ALARM_SECS_DEF = 8'd30;
  localparam logic [3:0]  BCD_MAX        = 4'd9;
  function automatic logic bcd_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction
endpackage

// File: rtl/timer_ctrl_btn_debounce.sv
// btn_debounce: synchronizes a raw button, accepts a level after DB_CYCLES stable samples, pulses on press
module btn_debounce
  import timer_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  logic [1:0]  sync;
  logic        level;
  logic        prev;
  logic [15:0] cnt;
  // two-flop synchronizer, stability counter and registered rising-edge pulse of the accepted level
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync  <= 2'b00;
      level <= 1'b0;
      prev  <= 1'b0;
      cnt   <= 16'd0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) cnt <= 16'd0;
      else if (cnt == DB_CYCLES - 16'd1) begin
        level <= sync[1];
        cnt   <= 16'd0;
      end else cnt <= cnt + 16'd1;
      prev  <= level;
      pulse <= level & ~prev;
    end
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: button-driven control FSM sequencing load/count of the MM:SS countdown and driving alarm LEDs
module timer_ctrl
  import timer_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES  = DB_CYCLES_DEF,
  parameter logic [7:0]  ALARM_SECS = ALARM_SECS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_load,
  input  logic       btn_clear,
  input  logic       tick,
  input  logic       zero,
  input  logic       bad_preset,
  output logic       load,
  output logic       ce,
  output logic       alarm,
  output logic       running,
  output logic [2:0] state
);
  state_t     st;
  logic [7:0] acnt;
  logic       start_p, load_p, clear_p;
  logic       sp, lp, cp, any_p;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (.clk(clk), .reset(reset), .raw(btn_start), .pulse(start_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load  (.clk(clk), .reset(reset), .raw(btn_load),  .pulse(load_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (.clk(clk), .reset(reset), .raw(btn_clear), .pulse(clear_p));
  assign cp      = clear_p;
  assign lp      = load_p & ~clear_p;
  assign sp      = start_p & ~clear_p & ~load_p;
  assign any_p   = start_p | load_p | clear_p;
  assign ce      = tick & (st == RUN) & ~zero;
  assign running = (st == RUN);
  assign state   = st;
  // control FSM with registered load pulse, alarm LED and alarm tick counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st    <= IDLE;
      load  <= 1'b0;
      alarm <= 1'b0;
      acnt  <= 8'd0;
    end else begin
      load <= 1'b0;
      case (st)
        IDLE:
          if (lp) begin
            st    <= bad_preset ? FAULT : ARMED;
            load  <= ~bad_preset;
            alarm <= bad_preset;
          end
        ARMED:
          if (cp) st <= IDLE;
          else if (lp) begin
            st    <= bad_preset ? FAULT : ARMED;
            load  <= ~bad_preset;
            alarm <= bad_preset;
          end else if (sp && !zero) st <= RUN;
        RUN:
          if (zero) begin
            st    <= ALARM;
            alarm <= 1'b1;
            acnt  <= 8'd0;
          end else if (cp) st <= IDLE;
          else if (sp) st <= PAUSE;
        PAUSE:
          if (cp) st <= IDLE;
          else if (lp) begin
            st    <= bad_preset ? FAULT : ARMED;
            load  <= ~bad_preset;
            alarm <= bad_preset;
          end else if (sp) st <= RUN;
        ALARM:
          if (any_p || (tick && acnt == ALARM_SECS - 8'd1)) begin
            st    <= IDLE;
            alarm <= 1'b0;
            acnt  <= 8'd0;
          end else if (tick) begin
            acnt  <= acnt + 8'd1;
            alarm <= ~alarm;
          end
        FAULT:
          if (cp) begin
            st    <= IDLE;
            alarm <= 1'b0;
          end else if (lp && !bad_preset) begin
            st    <= ARMED;
            load  <= 1'b1;
            alarm <= 1'b0;
          end else alarm <= 1'b1;
        default: begin
          st    <= IDLE;
          alarm <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl with short debounce and alarm lengths
module tb_timer_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0, btn_load = 1'b0, btn_clear = 1'b0;
  logic       tick = 1'b0, zero = 1'b0, bad_preset = 1'b0;
  logic       load, ce, alarm, running;
  logic [2:0] state;
  int         checks = 0, errors = 0;
  int         ld_cnt = 0, ce_cnt = 0;
  int         l0, c0;

  timer_ctrl #(.DB_CYCLES(16'd4), .ALARM_SECS(8'd3)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_load(btn_load), .btn_clear(btn_clear),
    .tick(tick), .zero(zero), .bad_preset(bad_preset),
    .load(load), .ce(ce), .alarm(alarm), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) ld_cnt <= ld_cnt + 1;
    if (ce) ce_cnt <= ce_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic one_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
  endtask

  initial begin
    tick = 1'b1;
    step(2);
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_load", {7'd0, load}, 8'd0);
    chk("rst_alarm", {7'd0, alarm}, 8'd0);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_ce", {7'd0, ce}, 8'd0);
    tick = 1'b0;
    reset = 1'b1;
    step(2);

    btn_load = 1'b1;
    step(7);
    chk("load_early", {7'd0, load}, 8'd0);
    step(1);
    chk("load_at8", {7'd0, load}, 8'd1);
    chk("armed", {5'd0, state}, 8'd1);
    step(1);
    chk("load_1cyc", {7'd0, load}, 8'd0);
    step(1);
    btn_load = 1'b0;
    step(10);
    chk("release_quiet", {5'd0, state}, 8'd1);
    btn_start = 1'b1;
    step(3);
    btn_start = 1'b0;
    step(12);
    chk("glitch_ignored", {5'd0, state}, 8'd1);

    btn_start = 1'b1;
    step(8);
    chk("run_state", {5'd0, state}, 8'd2);
    chk("run_running", {7'd0, running}, 8'd1);
    btn_start = 1'b0;
    step(10);
    tick = 1'b1;
    #1 chk("ce_on_tick", {7'd0, ce}, 8'd1);
    tick = 1'b0;
    step(2);
    c0 = ce_cnt;
    repeat (5) one_tick();
    chk("ce_count5", 8'(ce_cnt - c0), 8'd5);
    btn_start = 1'b1;
    step(8);
    chk("pause_state", {5'd0, state}, 8'd3);
    chk("pause_running", {7'd0, running}, 8'd0);
    btn_start = 1'b0;
    step(10);
    c0 = ce_cnt;
    tick = 1'b1;
    #1 chk("ce_paused", {7'd0, ce}, 8'd0);
    step(1);
    tick = 1'b0;
    step(2);
    repeat (2) one_tick();
    chk("ce_count_paused", 8'(ce_cnt - c0), 8'd0);
    btn_start = 1'b1;
    step(8);
    chk("resume_run", {5'd0, state}, 8'd2);
    btn_start = 1'b0;
    step(10);

    btn_start = 1'b1;
    step(7);
    zero = 1'b1;
    tick = 1'b1;
    #1 chk("ce_zero", {7'd0, ce}, 8'd0);
    tick = 1'b0;
    step(1);
    chk("alarm_state", {5'd0, state}, 8'd4);
    chk("alarm_on", {7'd0, alarm}, 8'd1);
    btn_start = 1'b0;
    step(10);
    chk("alarm_hold", {7'd0, alarm}, 8'd1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("alarm_t1", {7'd0, alarm}, 8'd0);
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("alarm_t2", {7'd0, alarm}, 8'd1);
    chk("alarm_t2_state", {5'd0, state}, 8'd4);
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("alarm_done_state", {5'd0, state}, 8'd0);
    chk("alarm_done", {7'd0, alarm}, 8'd0);
    zero = 1'b0;
    step(2);

    bad_preset = 1'b1;
    l0 = ld_cnt;
    btn_load = 1'b1;
    step(8);
    chk("fault_state", {5'd0, state}, 8'd5);
    chk("fault_alarm", {7'd0, alarm}, 8'd1);
    btn_load = 1'b0;
    step(10);
    chk("fault_noload", 8'(ld_cnt - l0), 8'd0);
    chk("fault_steady", {7'd0, alarm}, 8'd1);
    bad_preset = 1'b0;
    btn_load = 1'b1;
    step(8);
    chk("fix_load", {7'd0, load}, 8'd1);
    chk("fix_state", {5'd0, state}, 8'd1);
    chk("fix_alarm", {7'd0, alarm}, 8'd0);
    btn_load = 1'b0;
    step(10);

    l0 = ld_cnt;
    btn_start = 1'b1;
    btn_load = 1'b1;
    btn_clear = 1'b1;
    step(8);
    chk("prio_state", {5'd0, state}, 8'd0);
    step(2);
    chk("prio_noload", 8'(ld_cnt - l0), 8'd0);
    btn_start = 1'b0;
    btn_load = 1'b0;
    btn_clear = 1'b0;
    step(10);

    btn_load = 1'b1;
    step(10);
    btn_load = 1'b0;
    step(10);
    btn_start = 1'b1;
    step(10);
    btn_start = 1'b0;
    step(10);
    chk("pre_rst_run", {5'd0, state}, 8'd2);
    one_tick();
    tick = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_state", {5'd0, state}, 8'd0);
    chk("arst_running", {7'd0, running}, 8'd0);
    chk("arst_ce", {7'd0, ce}, 8'd0);
    chk("arst_alarm", {7'd0, alarm}, 8'd0);
    chk("arst_load", {7'd0, load}, 8'd0);
    tick = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    chk("post_rst_state", {5'd0, state}, 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
